// File: rtl/alu_sweep_seq.sv
// alu_sweep_seq
//   Operand-sweep sequencer for the ALU. Once started it walks every
//   {a, carry, b} combination for one latched op code and presents each one on
//   a valid/ready stream, then pulses done and returns to idle.
//
//   Enumeration order: b changes fastest, then carry (carry_mode=1 only), then
//   a. The sweep stops on the final vector and never wraps back to zero.
//
// Ports
//   master_clk, rst_n        clock (rising edge) / async active-low reset
//   start, abort             begin sweep (IDLE only) / cancel sweep (RUN only)
//   op_in, carry_mode        op code and carry-sweep enable, latched on start
//   out_ready                downstream accepts the current vector
//   out_valid                a_out/b_out/carry_out/op_out hold a valid vector
//   a_out, b_out, carry_out  operands for the ALU
//   op_out                   latched op code
//   last                     current vector is the final one
//   busy                     high while sweeping
//   done                     one-cycle pulse after the final vector is accepted
//
// Configuration
//   ALU_SWEEP_STALL_CNT_EN   adds stall_cnt[15:0]: cycles with out_valid and
//                            !out_ready since the last accepted start, saturating.
module alu_sweep_seq #(
  parameter int A_WIDTH  = 8,
  parameter int B_WIDTH  = 2,
  parameter int OP_WIDTH = 4
) (
  input  logic                master_clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [OP_WIDTH-1:0] op_in,
  input  logic                carry_mode,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [A_WIDTH-1:0]  a_out,
  output logic [B_WIDTH-1:0]  b_out,
  output logic                carry_out,
  output logic [OP_WIDTH-1:0] op_out,
  output logic                last,
  output logic                busy,
  output logic                done
`ifdef ALU_SWEEP_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int CW = A_WIDTH + B_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OP_WIDTH-1:0] op_q;
  logic                cmode_q;

  logic                hs;
  logic                is_last;
  logic [CW-1:0]       last_idx;

  // Without carry sweep the top counter bit is unused, so the final index is
  // one bit shorter.
  assign last_idx = cmode_q ? {CW{1'b1}} : {1'b0, {(CW-1){1'b1}}};
  assign is_last  = (cnt_q == last_idx);
  assign hs       = out_valid & out_ready;
  assign cnt_d    = cnt_q + 1'b1;

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      cmode_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          cnt_q   <= '0;
          op_q    <= op_in;
          cmode_q <= carry_mode;
        end
        RUN: begin
          // abort takes priority over a handshake in the same cycle
          if (abort)       state_q <= IDLE;
          else if (hs) begin
            if (is_last)   state_q <= DONE;
            else           cnt_q   <= cnt_d;
          end
        end
        DONE:              state_q <= IDLE;
        default:           state_q <= IDLE;
      endcase
    end
  end

  // All outputs decode directly from flops, so they hold stable through stalls.
  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign last      = out_valid & is_last;
  assign op_out    = op_q;
  assign b_out     = cnt_q[B_WIDTH-1:0];
  assign carry_out = cmode_q & cnt_q[B_WIDTH];
  assign a_out     = cmode_q ? cnt_q[CW-1:B_WIDTH+1] : cnt_q[CW-2:B_WIDTH];

`ifdef ALU_SWEEP_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n)                                       stall_q <= '0;
    else if (state_q == IDLE && start)                stall_q <= '0;
    else if (out_valid && !out_ready && stall_q != 16'hFFFF)
                                                      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_alu_sweep_seq.sv
module tb_alu_sweep_seq;

  logic       master_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, carry_mode = 1'b0, out_ready = 1'b1;
  logic [3:0] op_in = '0;
  logic       out_valid, carry_out, last, busy, done;
  logic [1:0] a_out;
  logic [0:0] b_out;
  logic [3:0] op_out;

  // default-sized instance for the full 1024-vector sweep
  logic       start2 = 1'b0;
  logic       out_valid2, carry_out2, last2, busy2, done2;
  logic [7:0] a_out2;
  logic [1:0] b_out2;
  logic [3:0] op_out2;

`ifdef ALU_SWEEP_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt2;
`endif

  always #5 master_clk = ~master_clk;

  alu_sweep_seq #(.A_WIDTH(2), .B_WIDTH(1), .OP_WIDTH(4)) dut (
    .master_clk(master_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_in(op_in), .carry_mode(carry_mode), .out_ready(out_ready),
    .out_valid(out_valid), .a_out(a_out), .b_out(b_out), .carry_out(carry_out),
    .op_out(op_out), .last(last), .busy(busy), .done(done)
`ifdef ALU_SWEEP_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  alu_sweep_seq dut2 (
    .master_clk(master_clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
    .op_in(4'hA), .carry_mode(1'b0), .out_ready(1'b1),
    .out_valid(out_valid2), .a_out(a_out2), .b_out(b_out2), .carry_out(carry_out2),
    .op_out(op_out2), .last(last2), .busy(busy2), .done(done2)
`ifdef ALU_SWEEP_STALL_CNT_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  typedef struct {int a; int b; int c; int op; bit last;} vec_t;

  vec_t q[$];
  int   q2[$];
  int   n_checks = 0, n_fail = 0;
  int   hs_cnt = 0, done_seen = 0, stall_model = 0;
  int   rmode = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: index i of an N-vector sweep, b fastest, then carry, then a.
  task automatic push_sweep(input int op, input bit cm);
    int n;
    vec_t v;
    n = cm ? 16 : 8;
    for (int i = 0; i < n; i++) begin
      v.b    = i % 2;
      v.c    = cm ? (i / 2) % 2 : 0;
      v.a    = cm ? i / 4 : i / 2;
      v.op   = op;
      v.last = (i == n - 1);
      q.push_back(v);
    end
  endtask

  // out_ready patterns: 0 always ready, 1 alternating, 2 random
  always @(posedge master_clk) begin
    #1;
    case (rmode)
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  // Scoreboard monitor for the small instance
  vec_t prev;
  bit   have_prev = 0;
  always @(negedge master_clk) begin
    if (!rst_n) have_prev = 0;
    else begin
      if (have_prev && out_valid) begin
        chk("stall_hold_a", a_out, prev.a);
        chk("stall_hold_b", b_out, prev.b);
        chk("stall_hold_c", carry_out, prev.c);
        chk("stall_hold_last", last, prev.last);
      end
      have_prev = 0;
      if (out_valid) begin
        chk("unexpected_valid", q.size() != 0, 1);
        if (out_ready && q.size() != 0) begin
          vec_t e;
          e = q.pop_front();
          chk("a_out", a_out, e.a);
          chk("b_out", b_out, e.b);
          chk("carry_out", carry_out, e.c);
          chk("op_out", op_out, e.op);
          chk("last", last, e.last);
          chk("busy_in_run", busy, 1);
          hs_cnt++;
        end else if (!out_ready) begin
          prev.a = a_out; prev.b = b_out; prev.c = carry_out; prev.last = last;
          have_prev = 1;
          stall_model++;
        end
      end
      if (done) done_seen++;
    end
  end

  // Scoreboard monitor for the default instance
  always @(negedge master_clk) begin
    if (rst_n && out_valid2) begin
      chk("unexpected_valid2", q2.size() != 0, 1);
      if (q2.size() != 0) begin
        int e;
        e = q2.pop_front();
        chk("ab_out2", {a_out2, b_out2}, e);
        chk("last2", last2, e == 1023);
      end
    end
  end

  task automatic issue_start(input int op, input bit cm, input bit with_abort);
    @(posedge master_clk); #1;
    start = 1; op_in = 4'(op); carry_mode = cm; abort = with_abort;
    stall_model = 0;
    push_sweep(op, cm);
    @(posedge master_clk); #1;
    start = 0; abort = 0;
  endtask

  task automatic wait_hs(input int target);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge master_clk); #1;
      if (hs_cnt >= target) begin ok = 1; break; end
    end
    chk("wait_hs_timeout", ok, 1);
  endtask

  task automatic wait_done();
    bit ok = 0;
    int d0;
    d0 = done_seen;
    for (int i = 0; i < 200; i++) begin
      @(negedge master_clk); #1;
      if (q.size() == 0) begin ok = 1; break; end
    end
    chk("sweep_timeout", ok, 1);
    @(negedge master_clk); #1;
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("valid_at_done", out_valid, 0);
`ifdef ALU_SWEEP_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stall_model);
`endif
    @(negedge master_clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
    chk("done_count", done_seen - d0, 1);
  endtask

  initial begin
    int d0, base;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ab", {a_out, b_out, carry_out, op_out, last}, 0);
    #20 rst_n = 1;

    // plain sweep, 8 vectors
    rmode = 0;
    issue_start(5, 0, 0);
    wait_done();

    // carry sweep, 16 vectors; abort with start in IDLE must be ignored
    issue_start(9, 1, 1);
    wait_done();

    // alternating ready: every vector held through a stall
    rmode = 1;
    issue_start(3, 0, 0);
    wait_done();

    // random ready with carry sweep
    rmode = 2;
    issue_start(12, 1, 0);
    wait_done();
    rmode = 0;

    // abort after 3 handshakes, coincident with a handshake
    base = hs_cnt;
    d0 = done_seen;
    issue_start(7, 0, 0);
    wait_hs(base + 3);
    @(posedge master_clk); #1; abort = 1;
    @(posedge master_clk); #1; abort = 0;
    @(negedge master_clk); #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_hs", hs_cnt - base, 4);
    q.delete();
    repeat (3) @(negedge master_clk);
    #1 chk("abort_no_done", done_seen - d0, 0);
    issue_start(7, 0, 0);
    wait_done();

    // start with a new op mid-sweep must be ignored
    base = hs_cnt;
    issue_start(2, 0, 0);
    wait_hs(base + 2);
    @(posedge master_clk); #1; start = 1; op_in = 4'hF; carry_mode = 1;
    @(posedge master_clk); #1; start = 0;
    wait_done();
    chk("ignored_start_len", hs_cnt - base, 8);

    // async reset at vector 5
    base = hs_cnt;
    d0 = done_seen;
    issue_start(11, 1, 0);
    wait_hs(base + 5);
    #1 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_outs", {a_out, b_out, carry_out, op_out, last, done}, 0);
    q.delete();
    @(negedge master_clk); rst_n = 1;
    repeat (3) @(negedge master_clk);
    #1 chk("arst_no_done", done_seen - d0, 0);

    // default-size full sweep: 1024 vectors, last at a=FF b=3
    @(posedge master_clk); #1; start2 = 1;
    for (int i = 0; i < 1024; i++) q2.push_back(i);
    @(posedge master_clk); #1; start2 = 0;
    begin
      bit ok = 0;
      for (int i = 0; i < 1200; i++) begin
        @(negedge master_clk); #1;
        if (q2.size() == 0) begin ok = 1; break; end
      end
      chk("sweep2_timeout", ok, 1);
    end
    @(negedge master_clk); #1;
    chk("done2_pulse", done2, 1);
    chk("valid2_at_done", out_valid2, 0);
    @(negedge master_clk); #1;
    chk("done2_one_cycle", done2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
